seq_detect_param: RTL and testbench



---
 rtl/seq_detect_param.sv | 141 ++++++++++++++
 tb/tb_seq_detect_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector: matches a 1..MAX_LEN bit pattern
// in the sampled stream `w`, with overlapping or non-overlapping matching.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               en,
    input  logic               w,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               clr_cnt,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               sat,
    output logic               armed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W:0]   MAX_L_X = (LEN_W+1)'(MAX_LEN);

    state_t             state;
    state_t             state_n;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN:0]   hist_ext;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   len_clamped;
    logic               sample;
    logic               match;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        hist_ext    = {hist, w};
        hist_n      = hist_ext[MAX_LEN-1:0];
        sample      = en && !load;
        fill_p1     = {1'b0, fill} + (LEN_W+1)'(1);
        len_clamped = (len > MAX_L) ? MAX_L : len;

        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < cfg_len);
        end

        // fill+1 counts the bit being sampled right now
        match = sample && (state != IDLE)
             && (fill_p1 >= {1'b0, cfg_len})
             && (((hist_n ^ cfg_pat) & mask) == '0);

        fill_n = fill;
        if (sample) begin
            if (match && !cfg_ovl) begin
                fill_n = '0;
            end else if (fill_p1 >= MAX_L_X) begin
                fill_n = MAX_L;
            end else begin
                fill_n = fill_p1[LEN_W-1:0];
            end
        end

        state_n = state;
        if (load) begin
            state_n = (len_clamped == '0) ? IDLE : FILL;
        end else if (sample) begin
            case (state)
                IDLE:    state_n = IDLE;
                FILL:    state_n = (fill_n >= cfg_len) ? HUNT : FILL;
                HUNT:    state_n = (fill_n >= cfg_len) ? HUNT : FILL;
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the history register is small flop storage, not a RAM, and
            // must read as zero after reset, so it is reset like the rest.
            hist      <= '0;
            fill      <= '0;
            cfg_pat   <= '0;
            cfg_len   <= '0;
            cfg_ovl   <= 1'b0;
            state     <= IDLE;
            armed     <= 1'b0;
            z         <= 1'b0;
            match_cnt <= '0;
            sat       <= 1'b0;
        end else begin
            if (load) begin
                cfg_pat <= pattern;
                cfg_len <= len_clamped;
                cfg_ovl <= overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (en) begin
                hist <= hist_n;
                fill <= fill_n;
            end

            state <= state_n;
            armed <= (state_n == HUNT);
            z     <= match;

            // a clear coinciding with a match counts that match
            if (match) begin
                if (clr_cnt) begin
                    match_cnt <= CNT_W'(1);
                    sat       <= 1'b0;
                end else if (&match_cnt) begin
                    sat <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end else if (clr_cnt) begin
                match_cnt <= '0;
                sat       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               Clk = 1'b0;
    logic               Rst;
    logic               en;
    logic               w;
    logic               load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               clr_cnt;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               sat;
    logic               armed;

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (en),
        .w         (w),
        .load      (load),
        .pattern   (pattern),
        .len       (len),
        .overlap   (overlap),
        .clr_cnt   (clr_cnt),
        .z         (z),
        .match_cnt (match_cnt),
        .sat       (sat),
        .armed     (armed)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // reference model: bits seen since the last load or non-overlapping match
    bit               q[$];
    int               m_len;
    bit [MAX_LEN-1:0] m_pat;
    bit               m_ovl;
    int               m_cnt;
    bit               m_sat;
    bit               m_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_len = 0;
        m_pat = '0;
        m_ovl = 1'b0;
        m_cnt = 0;
        m_sat = 1'b0;
        m_z   = 1'b0;
    endtask

    task automatic model_step();
        bit hit;
        hit = 1'b0;
        if (load) begin
            q.delete();
            m_pat = pattern;
            m_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
            m_ovl = overlap;
        end else if (en) begin
            q.push_back(w);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            if (m_len != 0 && q.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
                end
                if (hit && !m_ovl) q.delete();
            end
        end
        m_z = hit;
        if (hit) begin
            if (clr_cnt) begin
                m_cnt = 1;
                m_sat = 1'b0;
            end else if (m_cnt == CNT_MAX) begin
                m_sat = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (clr_cnt) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        bit exp_armed;
        exp_armed = (m_len != 0) && (q.size() >= m_len);
        check({tag, ".z"},     32'(z),         32'(m_z));
        check({tag, ".cnt"},   32'(match_cnt), 32'(m_cnt));
        check({tag, ".sat"},   32'(sat),       32'(m_sat));
        check({tag, ".armed"}, 32'(armed),     32'(exp_armed));
    endtask

    // inputs are set before the call; outputs are compared 1 time unit after the edge
    task automatic step(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic sample_bit(input string tag, input bit e, input bit b);
        en = e;
        w  = b;
        step(tag);
        en = 1'b0;
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] p, input int l, input bit o);
        load    = 1'b1;
        pattern = p;
        len     = LEN_W'(l);
        overlap = o;
        step("load");
        load = 1'b0;
    endtask

    task automatic do_clear();
        clr_cnt = 1'b1;
        step("clr");
        clr_cnt = 1'b0;
    endtask

    initial begin
        Rst     = 1'b1;
        en      = 1'b0;
        w       = 1'b0;
        load    = 1'b0;
        pattern = '0;
        len     = '0;
        overlap = 1'b0;
        clr_cnt = 1'b0;
        model_reset();

        #12;
        check("rst.z",     32'(z),         32'd0);
        check("rst.cnt",   32'(match_cnt), 32'd0);
        check("rst.sat",   32'(sat),       32'd0);
        check("rst.armed", 32'(armed),     32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // idle: no configuration loaded, so no match however many ones arrive
        for (int i = 0; i < 20; i++) sample_bit("idle", 1'b1, 1'b1);
        check("idle.cnt_end", 32'(match_cnt), 32'd0);

        // overlapping 1001 on 1,0,0,1,0,0,1
        do_load(8'b1001, 4, 1'b1);
        begin
            bit s[7] = '{1, 0, 0, 1, 0, 0, 1};
            for (int i = 0; i < 7; i++) begin
                sample_bit("ovl", 1'b1, s[i]);
                if (i == 3) begin
                    check("ovl.z4",     32'(z),     32'd1);
                    check("ovl.armed4", 32'(armed), 32'd1);
                end
            end
            check("ovl.z7",  32'(z),         32'd1);
            check("ovl.cnt", 32'(match_cnt), 32'd2);

            // non-overlapping on the same stream
            do_clear();
            do_load(8'b1001, 4, 1'b0);
            for (int i = 0; i < 7; i++) begin
                sample_bit("novl", 1'b1, s[i]);
                if (i == 3) check("novl.z4", 32'(z), 32'd1);
            end
            check("novl.z7",   32'(z),         32'd0);
            check("novl.cnt",  32'(match_cnt), 32'd1);
            check("novl.armed", 32'(armed),    32'd0);
        end

        // gaps between samples and load priority over en
        do_clear();
        do_load(8'b101, 3, 1'b0);
        sample_bit("gap", 1'b1, 1'b1);
        sample_bit("gap", 1'b0, 1'b0);
        sample_bit("gap", 1'b1, 1'b0);
        sample_bit("gap", 1'b0, 1'b1);
        sample_bit("gap", 1'b0, 1'b0);
        sample_bit("gap", 1'b1, 1'b1);
        check("gap.z",   32'(z),         32'd1);
        check("gap.cnt", 32'(match_cnt), 32'd1);
        en = 1'b1;
        w  = 1'b1;
        do_load(8'b1, 1, 1'b0);
        en = 1'b0;
        check("ldpri.z", 32'(z), 32'd0);
        sample_bit("ldpri", 1'b1, 1'b1);
        check("ldpri.z_next", 32'(z), 32'd1);

        // saturation and clear-with-match
        do_clear();
        do_load(8'b1, 1, 1'b1);
        for (int i = 0; i < 255; i++) sample_bit("satrun", 1'b1, 1'b1);
        check("sat.cnt255", 32'(match_cnt), 32'd255);
        check("sat.flag0",  32'(sat),       32'd0);
        sample_bit("satrun", 1'b1, 1'b1);
        check("sat.cnt_hold", 32'(match_cnt), 32'd255);
        check("sat.flag1",    32'(sat),       32'd1);
        clr_cnt = 1'b1;
        sample_bit("satclr", 1'b1, 1'b1);
        clr_cnt = 1'b0;
        check("satclr.cnt", 32'(match_cnt), 32'd1);
        check("satclr.sat", 32'(sat),       32'd0);

        // asynchronous reset mid-operation
        do_clear();
        for (int i = 0; i < 5; i++) sample_bit("pre_rst", 1'b1, 1'b1);
        check("pre_rst.cnt",   32'(match_cnt), 32'd5);
        check("pre_rst.armed", 32'(armed),     32'd1);
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        check("arst.z",     32'(z),         32'd0);
        check("arst.cnt",   32'(match_cnt), 32'd0);
        check("arst.sat",   32'(sat),       32'd0);
        check("arst.armed", 32'(armed),     32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) sample_bit("post_rst", 1'b1, 1'b1);
        check("post_rst.cnt", 32'(match_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load    = ($urandom_range(0, 39) == 0);
            clr_cnt = ($urandom_range(0, 59) == 0);
            en      = ($urandom_range(0, 3) != 0);
            w       = 1'($urandom_range(0, 1));
            pattern = MAX_LEN'($urandom);
            len     = ($urandom_range(0, 9) < 7) ? LEN_W'($urandom_range(1, 3))
                                                 : LEN_W'($urandom_range(0, 15));
            overlap = 1'($urandom_range(0, 1));
            step("rand");
        end
        load    = 1'b0;
        clr_cnt = 1'b0;
        en      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
